// File: rtl/datapath_sequencer_pkg.sv
// Shared types and constants for the datapath sequencer: FSM states, class codes,
// PC-control codes, instruction field positions and the control-word layout.
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_IMM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  localparam logic [2:0] CLS_ALU_RR = 3'b000;
  localparam logic [2:0] CLS_ALU_RI = 3'b001;
  localparam logic [2:0] CLS_LD     = 3'b010;
  localparam logic [2:0] CLS_ST     = 3'b011;
  localparam logic [2:0] CLS_BRZ    = 3'b100;
  localparam logic [2:0] CLS_JMP    = 3'b101;
  localparam logic [2:0] CLS_NOP    = 3'b110;
  localparam logic [2:0] CLS_HALT   = 3'b111;

  localparam logic [3:0] FSEL_SUB = 4'h5;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;

  localparam int CLS_MSB  = 15;
  localparam int CLS_LSB  = 13;
  localparam int DR_MSB   = 12;
  localparam int DR_LSB   = 10;
  localparam int SA_MSB   = 9;
  localparam int SA_LSB   = 7;
  localparam int SB_MSB   = 6;
  localparam int SB_LSB   = 4;
  localparam int FSEL_MSB = 3;
  localparam int FSEL_LSB = 0;

  typedef struct packed {
    logic       wr;
    logic       mw;
    logic       ma;
    logic       md;
    logic       mb;
    logic       ir_l;
    logic [1:0] ps;
    logic       cin;
    logic       halted;
  } ctrl_t;

  // Classes that carry an immediate word after the opcode word.
  function automatic logic is_two_word(input logic [2:0] cls);
    return (cls == CLS_ALU_RI) || (cls == CLS_BRZ) || (cls == CLS_JMP);
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Sequencer <-> datapath bundle: status/instruction inputs and every control strobe.
// master = sequencer side, slave = datapath side.
interface datapath_sequencer_if #(
  parameter int W  = 16,
  parameter int RA = 3
);
  logic [W-1:0]  ir;
  logic [W-1:0]  mem_data;
  logic          z_flag;
  logic [RA-1:0] AA;
  logic [RA-1:0] BA;
  logic [RA-1:0] DA;
  logic [4:0]    FS;
  logic          Cin;
  logic [W-1:0]  k;
  logic          MB;
  logic          WR;
  logic          MW;
  logic          MA;
  logic          MD;
  logic          IR_L;
  logic [1:0]    PS;
  logic          halted;

  modport master (
    input  ir, mem_data, z_flag,
    output AA, BA, DA, FS, Cin, k, MB, WR, MW, MA, MD, IR_L, PS, halted
  );

  modport slave (
    output ir, mem_data, z_flag,
    input  AA, BA, DA, FS, Cin, k, MB, WR, MW, MA, MD, IR_L, PS, halted
  );
endinterface

// File: rtl/datapath_sequencer_decode.sv
// Combinational state/class -> control-word decode; zero latency, no backpressure.
// clear forces every strobe low so an aborted instruction never writes.
module seq_decode
  import seq_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] cls,
  input  logic [3:0] fsel,
  input  logic       z_flag,
  input  logic       clear,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!clear) begin
      ctrl.cin = (fsel == FSEL_SUB);
      case (state)
        S_FETCH: begin
          ctrl.ir_l = 1'b1;
          ctrl.ps   = PS_INC;
        end
        S_IMM: begin
          ctrl.ps = PS_INC;
        end
        S_EXEC: begin
          case (cls)
            CLS_ALU_RR: ctrl.wr = 1'b1;
            CLS_ALU_RI: begin
              ctrl.wr = 1'b1;
              ctrl.mb = 1'b1;
            end
            CLS_LD: begin
              ctrl.ma = 1'b1;
              ctrl.md = 1'b1;
              ctrl.wr = 1'b1;
            end
            CLS_ST: begin
              ctrl.ma = 1'b1;
              ctrl.mw = 1'b1;
            end
            CLS_BRZ: ctrl.ps = z_flag ? PS_LOAD : PS_HOLD;
            CLS_JMP: ctrl.ps = PS_LOAD;
            default: ;
          endcase
        end
        S_HALT: ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/IMM/EXEC control unit for the 8x16 regfile/ALU datapath;
// 3 cycles per single-word, 4 per two-word instruction; SEQ_SINGLE_STEP_EN adds step/WAIT gating.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int W  = 16,
  parameter int RA = 3
)(
  input  logic clock_50,
  input  logic clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  datapath_sequencer_if.master bus
);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t RESET_STATE = S_WAIT;
`else
  localparam state_t RESET_STATE = S_FETCH;
`endif

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  k_q;
  ctrl_t         ctrl;
  logic [2:0]    cls;
  logic [3:0]    fsel;
  logic [RA-1:0] dr;
  logic [RA-1:0] sa;
  logic [RA-1:0] sb;

  assign cls  = bus.ir[CLS_MSB:CLS_LSB];
  assign dr   = bus.ir[DR_MSB:DR_LSB];
  assign sa   = bus.ir[SA_MSB:SA_LSB];
  assign sb   = bus.ir[SB_MSB:SB_LSB];
  assign fsel = bus.ir[FSEL_MSB:FSEL_LSB];

  always_ff @(posedge clock_50) begin
    if (clear) begin
      state_q <= RESET_STATE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IMM) k_q <= bus.mem_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls == CLS_HALT)      state_d = S_HALT;
        else if (is_two_word(cls)) state_d = S_IMM;
        else                       state_d = S_EXEC;
      end
      S_IMM:    state_d = S_EXEC;
`ifdef SEQ_SINGLE_STEP_EN
      S_EXEC:   state_d = S_WAIT;
      S_WAIT:   if (step) state_d = S_FETCH;
`else
      S_EXEC:   state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  seq_decode u_decode (
    .state  (state_q),
    .cls    (cls),
    .fsel   (fsel),
    .z_flag (bus.z_flag),
    .clear  (clear),
    .ctrl   (ctrl)
  );

  // Register selects follow ir in every state, including while clear is high.
  assign bus.AA     = sa;
  assign bus.BA     = sb;
  assign bus.DA     = dr;
  assign bus.FS     = {1'b0, fsel};
  assign bus.k      = k_q;
  assign bus.Cin    = ctrl.cin;
  assign bus.MB     = ctrl.mb;
  assign bus.WR     = ctrl.wr;
  assign bus.MW     = ctrl.mw;
  assign bus.MA     = ctrl.ma;
  assign bus.MD     = ctrl.md;
  assign bus.IR_L   = ctrl.ir_l;
  assign bus.PS     = ctrl.ps;
  assign bus.halted = ctrl.halted;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed scoreboard bench: the driver queues per-cycle expected controls, a monitor compares at negedge.
module tb_datapath_sequencer;

  logic clock_50 = 1'b0;
  logic clear    = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
  logic step     = 1'b1;
`endif

  always #5 clock_50 = ~clock_50;

  datapath_sequencer_if #(.W(16), .RA(3)) bus ();

  datapath_sequencer #(.W(16), .RA(3)) dut (
    .clock_50 (clock_50),
    .clear    (clear),
`ifdef SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .bus      (bus)
  );

  // {WR, MW, MA, MD, MB, IR_L, PS[1:0], halted}
  localparam logic [8:0] X_NONE  = 9'b000000000;
  localparam logic [8:0] X_FETCH = 9'b000001010;
  localparam logic [8:0] X_IMM   = 9'b000000010;
  localparam logic [8:0] X_RR    = 9'b100000000;
  localparam logic [8:0] X_RI    = 9'b100010000;
  localparam logic [8:0] X_LD    = 9'b101100000;
  localparam logic [8:0] X_ST    = 9'b011000000;
  localparam logic [8:0] X_BR    = 9'b000000100;
  localparam logic [8:0] X_HALT  = 9'b000000001;

  typedef struct {
    string       tag;
    logic [39:0] v;
    logic        k_chk;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] k_m    = 16'h0000;

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic tick(input string tag, input logic clr, input logic [15:0] i,
                      input logic [15:0] md, input logic z, input logic [8:0] s,
                      input logic cin, input logic [15:0] kexp, input logic k_chk);
    exp_t e;
    clear        = clr;
    bus.ir       = i;
    bus.mem_data = md;
    bus.z_flag   = z;
    e.tag   = tag;
    e.v     = {s, cin, kexp, 1'b0, i[3:0], i[12:10], i[9:7], i[6:4]};
    e.k_chk = k_chk;
    exp_q.push_back(e);
    @(posedge clock_50);
    #1;
  endtask

  task automatic one_word(input string tag, input logic [15:0] i, input logic [8:0] s_exec);
    logic c;
    c = (i[3:0] == 4'h5);
    tick({tag, "_fetch"},  1'b0, i, 16'h0, 1'b0, X_FETCH, c, k_m, 1'b1);
    tick({tag, "_decode"}, 1'b0, i, 16'h0, 1'b0, X_NONE,  c, k_m, 1'b1);
    tick({tag, "_exec"},   1'b0, i, 16'h0, 1'b0, s_exec,  c, k_m, 1'b1);
  endtask

  // z_flag is held inverted outside EXEC so only the EXEC sample can matter.
  task automatic two_word(input string tag, input logic [15:0] i, input logic [15:0] md,
                          input logic z, input logic [8:0] s_exec);
    logic c;
    c = (i[3:0] == 4'h5);
    tick({tag, "_fetch"},  1'b0, i, 16'hFFFF, ~z, X_FETCH, c, k_m, 1'b1);
    tick({tag, "_decode"}, 1'b0, i, 16'hFFFF, ~z, X_NONE,  c, k_m, 1'b1);
    tick({tag, "_imm"},    1'b0, i, md,       ~z, X_IMM,   c, k_m, 1'b1);
    k_m = md;
    tick({tag, "_exec"},   1'b0, i, 16'hFFFF, z,  s_exec,  c, k_m, 1'b1);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [39:0] obs;
    logic [39:0] m;
    forever begin
      @(negedge clock_50);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        obs = {bus.WR, bus.MW, bus.MA, bus.MD, bus.MB, bus.IR_L, bus.PS, bus.halted,
               bus.Cin, bus.k, bus.FS, bus.DA, bus.AA, bus.BA};
        m = {40{1'b1}};
        if (!e.k_chk) m[29:14] = 16'h0;
        n_cmp++;
        if ((obs & m) !== (e.v & m)) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (mask %h)", e.tag, obs, e.v, m);
        end
      end
    end
  end

  initial begin : driver
    bus.ir       = 16'h0000;
    bus.mem_data = 16'h0000;
    bus.z_flag   = 1'b0;
    clear        = 1'b1;
    @(posedge clock_50);
    #1;
    tick("reset0", 1'b1, 16'h0000, 16'h0, 1'b0, X_NONE, 1'b0, 16'h0, 1'b1);
    tick("reset1", 1'b1, 16'h0000, 16'h0, 1'b0, X_NONE, 1'b0, 16'h0, 1'b1);

    one_word("alu_rr", 16'h0495, X_RR);
    two_word("alu_ri", 16'h2002, 16'h00AB, 1'b0, X_RI);
    two_word("brz_taken", 16'h8000, 16'h0040, 1'b1, X_BR);
    two_word("brz_not", 16'h8000, 16'h0077, 1'b0, X_NONE);
    two_word("jmp", 16'hA000, 16'h0123, 1'b0, X_BR);
    one_word("nop", 16'hC000, X_NONE);
    one_word("st", 16'h6000, X_ST);
    one_word("ld", 16'h4000, X_LD);

    // Abort LD in EXEC: no write that cycle, then a clean FETCH with k cleared.
    tick("ld_abort_fetch",  1'b0, 16'h4000, 16'h0, 1'b0, X_FETCH, 1'b0, k_m, 1'b1);
    tick("ld_abort_decode", 1'b0, 16'h4000, 16'h0, 1'b0, X_NONE,  1'b0, k_m, 1'b1);
    tick("ld_abort_exec",   1'b1, 16'h4000, 16'h0, 1'b0, X_NONE,  1'b0, k_m, 1'b0);
    k_m = 16'h0000;
    one_word("ld_after_abort", 16'h4000, X_LD);

    tick("halt_fetch",  1'b0, 16'hE000, 16'h0, 1'b0, X_FETCH, 1'b0, k_m, 1'b1);
    tick("halt_decode", 1'b0, 16'hE000, 16'h0, 1'b0, X_NONE,  1'b0, k_m, 1'b1);
    for (int n = 0; n < 20; n++)
      tick("halt_hold", 1'b0, 16'hE000, 16'h0, 1'b1, X_HALT, 1'b0, k_m, 1'b1);
    tick("halt_clear", 1'b1, 16'hE000, 16'h0, 1'b0, X_NONE, 1'b0, k_m, 1'b1);
    one_word("alu_rr_after_halt", 16'h0495, X_RR);

    clear = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clock_50);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
